alt_vipcti_avalon_csr_bank: RTL

//  Parametrised Avalon-MM control/status register bank for VIP cores; replaces the fixed-width slave.

---
 rtl/alt_vipcti_csr_pkg.sv | 28 ++
 rtl/alt_vipcti_csr_irq_unit.sv | 43 ++++
 rtl/alt_vipcti_avalon_csr_bank.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alt_vipcti_csr_pkg.sv
// Shared CSR address map and byte-lane merge helper for the VIP CSR bank.
package alt_vipcti_csr_pkg;

    localparam int unsigned CSR_CTRL_ADDR   = 0;
    localparam int unsigned CSR_STATUS_ADDR = 1;
    localparam int unsigned CSR_IRQ_ADDR    = 2;
    localparam int unsigned CSR_USER_BASE   = 3;

    // Widest data bus the merge helper supports; callers zero-extend into it.
    localparam int unsigned CSR_MAX_DATA_W  = 256;
    localparam int unsigned CSR_MAX_BE_W    = CSR_MAX_DATA_W / 8;

    function automatic logic [CSR_MAX_DATA_W-1:0] byte_merge(
        input logic [CSR_MAX_DATA_W-1:0] old_w,
        input logic [CSR_MAX_DATA_W-1:0] new_w,
        input logic [CSR_MAX_BE_W-1:0]   be
    );
        logic [CSR_MAX_DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < int'(CSR_MAX_BE_W); b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alt_vipcti_csr_irq_unit.sv
// Interrupt unit: rising-edge detect, enable gating, sticky W1C status and irq OR.
module alt_vipcti_csr_irq_unit
    import alt_vipcti_csr_pkg::*;
#(
    parameter int unsigned NO_INTERRUPTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NO_INTERRUPTS-1:0] interrupts,
    input  logic [NO_INTERRUPTS-1:0] irq_en,
    input  logic [NO_INTERRUPTS-1:0] clr,
    output logic [NO_INTERRUPTS-1:0] status,
    output logic                     irq
);

    logic [NO_INTERRUPTS-1:0] hist_q;
    logic [NO_INTERRUPTS-1:0] status_q;
    logic [NO_INTERRUPTS-1:0] status_d;
    logic                     irq_q;
    logic                     irq_d;

    // A new edge wins over a simultaneous W1C clear.
    always_comb begin
        status_d = (status_q & ~clr) | (interrupts & ~hist_q & irq_en);
        irq_d    = |status_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            hist_q   <= interrupts;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign status = status_q;
    assign irq    = irq_q;

endmodule

// File: rtl/alt_vipcti_avalon_csr_bank.sv
// Avalon-MM CSR bank: go/irq-enable ctrl, status, W1C interrupts and user registers.
// Define ALT_VIPCTI_CSR_SHADOW_EN to double-buffer user registers behind commit.
module alt_vipcti_avalon_csr_bank
    import alt_vipcti_csr_pkg::*;
#(
    parameter int unsigned AV_ADDRESS_WIDTH = 5,
    parameter int unsigned AV_DATA_WIDTH    = 32,
    parameter int unsigned NO_OUTPUTS       = 1,
    parameter int unsigned NO_INTERRUPTS    = 2,
    parameter int unsigned NO_REGISTERS     = 8,
    parameter logic [NO_REGISTERS-1:0] RO_MASK = '0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [AV_ADDRESS_WIDTH-1:0]           av_address,
    input  logic                                  av_read,
    input  logic                                  av_write,
    input  logic [AV_DATA_WIDTH/8-1:0]            av_byteenable,
    input  logic [AV_DATA_WIDTH-1:0]              av_writedata,
    output logic [AV_DATA_WIDTH-1:0]              av_readdata,
    output logic                                  av_readdatavalid,
    output logic                                  av_irq,
    output logic                                  enable,
    input  logic                                  clear_enable,
    input  logic                                  commit,
    output logic [NO_REGISTERS-1:0]               triggers,
    output logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers,
    input  logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers_in,
    input  logic [NO_REGISTERS-1:0]               registers_write,
    input  logic [NO_INTERRUPTS-1:0]              interrupts,
    input  logic [NO_OUTPUTS-1:0]                 stopped
);

    localparam int unsigned DW     = AV_DATA_WIDTH;
    localparam int unsigned AW     = AV_ADDRESS_WIDTH;
    localparam int unsigned BE_W   = AV_DATA_WIDTH / 8;
    localparam int unsigned CTRL_W = NO_INTERRUPTS + 1;

    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0]   old_w,
        input logic [DW-1:0]   new_w,
        input logic [BE_W-1:0] be
    );
        return DW'(byte_merge(CSR_MAX_DATA_W'(old_w), CSR_MAX_DATA_W'(new_w), CSR_MAX_BE_W'(be)));
    endfunction

    logic [CTRL_W-1:0]                 ctrl_q, ctrl_d;
    logic                              wr_ctrl, wr_irq;
    logic [NO_INTERRUPTS-1:0]          irq_clr, irq_status;
    logic [NO_REGISTERS-1:0][DW-1:0]   live_q, live_d, reg_in;
    logic [NO_REGISTERS-1:0]           user_wr;
    logic [NO_REGISTERS-1:0]           trig_q, trig_d;
    logic [DW-1:0]                     rd_word;
    logic [DW-1:0]                     rdata_q, rdata_d;
    logic                              rvalid_q;
`ifdef ALT_VIPCTI_CSR_SHADOW_EN
    logic [NO_REGISTERS-1:0][DW-1:0]   shadow_q, shadow_d;
`else
    logic                              unused_commit;
    assign unused_commit = commit;
`endif

    assign reg_in = registers_in;

    // Control register: go bit survives clear_enable only when written with byte 0 enabled.
    always_comb begin
        wr_ctrl = av_write && (av_address == AW'(CSR_CTRL_ADDR));
        wr_irq  = av_write && (av_address == AW'(CSR_IRQ_ADDR));
        ctrl_d  = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d = CTRL_W'(merge_bytes(DW'(ctrl_q), av_writedata, av_byteenable));
        end
        if (clear_enable && !(wr_ctrl && av_byteenable[0])) begin
            ctrl_d[0] = 1'b0;
        end
        irq_clr = '0;
        for (int k = 1; k <= int'(NO_INTERRUPTS); k++) begin
            irq_clr[k-1] = wr_irq && av_writedata[k] && av_byteenable[k/8];
        end
    end

    // User registers: master write beats internal write; RO registers ignore the master.
    always_comb begin
        live_d = live_q;
        trig_d = '0;
`ifdef ALT_VIPCTI_CSR_SHADOW_EN
        shadow_d = shadow_q;
`endif
        for (int i = 0; i < int'(NO_REGISTERS); i++) begin
            user_wr[i] = av_write && !RO_MASK[i] && (av_address == AW'(CSR_USER_BASE + i));
            trig_d[i]  = user_wr[i];
`ifdef ALT_VIPCTI_CSR_SHADOW_EN
            if (user_wr[i]) begin
                shadow_d[i] = merge_bytes(shadow_q[i], av_writedata, av_byteenable);
            end else if (registers_write[i]) begin
                shadow_d[i] = reg_in[i];
            end
            if (commit) begin
                live_d[i] = shadow_d[i];
            end else if (registers_write[i]) begin
                live_d[i] = reg_in[i];
            end
`else
            if (user_wr[i]) begin
                live_d[i] = merge_bytes(live_q[i], av_writedata, av_byteenable);
            end else if (registers_write[i]) begin
                live_d[i] = reg_in[i];
            end
`endif
        end
    end

    // Read mux sees pre-write values, so a same-cycle write is not reflected.
    always_comb begin
        rd_word = '0;
        if (av_address == AW'(CSR_CTRL_ADDR)) begin
            rd_word = DW'(ctrl_q);
        end else if (av_address == AW'(CSR_STATUS_ADDR)) begin
            rd_word = DW'(&stopped);
        end else if (av_address == AW'(CSR_IRQ_ADDR)) begin
            rd_word = DW'({irq_status, 1'b0});
        end
        for (int i = 0; i < int'(NO_REGISTERS); i++) begin
            if (av_address == AW'(CSR_USER_BASE + i)) begin
`ifdef ALT_VIPCTI_CSR_SHADOW_EN
                rd_word = shadow_q[i];
`else
                rd_word = live_q[i];
`endif
            end
        end
        rdata_d = av_read ? rd_word : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            live_q   <= '0;
            trig_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef ALT_VIPCTI_CSR_SHADOW_EN
            shadow_q <= '0;
`endif
        end else begin
            ctrl_q   <= ctrl_d;
            live_q   <= live_d;
            trig_q   <= trig_d;
            rdata_q  <= rdata_d;
            rvalid_q <= av_read;
`ifdef ALT_VIPCTI_CSR_SHADOW_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    alt_vipcti_csr_irq_unit #(
        .NO_INTERRUPTS (NO_INTERRUPTS)
    ) u_irq (
        .clk        (clk),
        .rst        (rst),
        .interrupts (interrupts),
        .irq_en     (ctrl_q[CTRL_W-1:1]),
        .clr        (irq_clr),
        .status     (irq_status),
        .irq        (av_irq)
    );

    assign enable           = ctrl_q[0];
    assign triggers         = trig_q;
    assign registers        = live_q;
    assign av_readdata      = rdata_q;
    assign av_readdatavalid = rvalid_q;

endmodule
